// File: rtl/cursor_fire_unit.sv
// cursor_fire_unit: player cursor, shot resolution and PC-board storage.
// The 5x5 board holds 3-bit cells: 0 water, 1 boat, 2 hit, 3 miss; 4..7 are
// kept as written and count as water.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | not the player's turn; placement writes accepted
// AIM     | cursor moves, fire accepted, turn timer running
// RESOLVE | target cell latched, outcome computed
// REPORT  | board shows result, hit/miss/shot_done visible
// WAIT    | turn over, hold until enable drops
module cursor_fire_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 750000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        move_h,
  input  logic        move_v,
  input  logic        fire,
  input  logic        direction,
  input  logic        load_en,
  input  logic [2:0]  load_row,
  input  logic [2:0]  load_col,
  input  logic [2:0]  load_val,
  output logic [74:0] board_flat,
  output logic [2:0]  cur_row,
  output logic [2:0]  cur_col,
  output logic        hit,
  output logic        miss,
  output logic        shot_done,
  output logic        shot_invalid,
  output logic        time_expired,
  output logic [4:0]  cells_left,
  output logic        all_sunk
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_AIM     = 3'd1;
  localparam logic [2:0] S_RESOLVE = 3'd2;
  localparam logic [2:0] S_REPORT  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    row_q, row_d, col_q, col_d;
  logic [4:0]    tgt_q, tgt_d;
  logic [74:0]   board_q, board_d;
  logic [4:0]    cells_q, cells_d;
  logic          seen_q, seen_d;
  logic          hit_q, hit_d, miss_q, miss_d, done_q, done_d;
  logic          inv_q, inv_d, exp_q, exp_d;

  // button synchronizers: bit 0 move_h, bit 1 move_v, bit 2 fire
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic       ev_h, ev_v, ev_f;

  logic       ld_ok;
  logic [4:0] cur_idx, ld_idx;
  logic [6:0] cur_base, tgt_base, ld_base;
  logic [2:0] cur_cell, tgt_cell, ld_cell;

  function automatic logic [2:0] step_pos(input logic [2:0] pos, input logic up);
    if (up) return (pos >= 3'd4) ? 3'd0 : pos + 3'd1;
    else    return (pos == 3'd0) ? 3'd4 : pos - 3'd1;
  endfunction

  assign ev_h = sync2_q[0] & ~prev_q[0];
  assign ev_v = sync2_q[1] & ~prev_q[1];
  assign ev_f = sync2_q[2] & ~prev_q[2];

  assign ld_ok    = (load_row < 3'd5) && (load_col < 3'd5);
  assign cur_idx  = 5'(row_q) * 5'd5 + 5'(col_q);
  assign ld_idx   = ld_ok ? (5'(load_row) * 5'd5 + 5'(load_col)) : 5'd0;
  assign cur_base = 7'(cur_idx) * 7'd3;
  assign tgt_base = 7'(tgt_q) * 7'd3;
  assign ld_base  = 7'(ld_idx) * 7'd3;
  assign cur_cell = board_q[cur_base +: 3];
  assign tgt_cell = board_q[tgt_base +: 3];
  assign ld_cell  = board_q[ld_base +: 3];

  // next-state, cursor, board and counter update
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    row_d   = row_q;
    col_d   = col_q;
    tgt_d   = tgt_q;
    board_d = board_q;
    cells_d = cells_q;
    seen_d  = seen_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    done_d  = 1'b0;
    inv_d   = 1'b0;
    exp_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en && ld_ok) begin
          board_d[ld_base +: 3] = load_val;
          if (load_val == 3'd1 && ld_cell != 3'd1) cells_d = cells_q + 5'd1;
          else if (load_val != 3'd1 && ld_cell == 3'd1) cells_d = cells_q - 5'd1;
        end
        if (enable) begin
          state_d = S_AIM;
          timer_d = '0;
        end
      end
      S_AIM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (ev_h) col_d = step_pos(col_q, direction);
          if (ev_v) row_d = step_pos(row_q, direction);
          // the shot uses the cursor as it was before any same-cycle move
          if (ev_f) begin
            if (cur_cell == 3'd2 || cur_cell == 3'd3) begin
              inv_d = 1'b1;
            end else begin
              tgt_d   = cur_idx;
              state_d = S_RESOLVE;
            end
          end else if (timer_q >= T_LAST) begin
            exp_d   = 1'b1;
            state_d = S_WAIT;
          end
          // saturate so an invalid shot on the last cycle still times out next
          if (timer_q < T_LAST) timer_d = timer_q + TW'(1);
        end
      end
      S_RESOLVE: begin
        state_d = S_REPORT;
        done_d  = 1'b1;
        if (tgt_cell == 3'd1) begin
          board_d[tgt_base +: 3] = 3'd2;
          cells_d = cells_q - 5'd1;
          seen_d  = 1'b1;
          hit_d   = 1'b1;
        end else begin
          board_d[tgt_base +: 3] = 3'd3;
          miss_d  = 1'b1;
        end
      end
      S_REPORT: state_d = S_WAIT;
      S_WAIT:   if (!enable) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // registered state with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      tgt_q   <= 5'd0;
      board_q <= '0;
      cells_q <= 5'd0;
      seen_q  <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
      exp_q   <= 1'b0;
      sync1_q <= 3'd0;
      sync2_q <= 3'd0;
      prev_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tgt_q   <= tgt_d;
      board_q <= board_d;
      cells_q <= cells_d;
      seen_q  <= seen_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
      exp_q   <= exp_d;
      sync1_q <= {fire, move_v, move_h};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign board_flat   = board_q;
  assign cur_row      = row_q;
  assign cur_col      = col_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign shot_done    = done_q;
  assign shot_invalid = inv_q;
  assign time_expired = exp_q;
  assign cells_left   = cells_q;
  assign all_sunk     = (cells_q == 5'd0) && seen_q;

endmodule
